// File: rtl/seq_mac_axil.sv
// rtl/seq_mac_axil.sv - AXI4-Lite sequential signed/unsigned multiply-accumulate engine
module seq_mac_axil #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int OP_WIDTH   = 32
) (
    input  logic                      s2_axi_aclk,
    input  logic                      s2_axi_areset,
    input  logic [ADDR_WIDTH-1:0]     s2_axi_awaddr,
    input  logic                      s2_axi_awvalid,
    output logic                      s2_axi_awready,
    input  logic [DATA_WIDTH-1:0]     s2_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]   s2_axi_wstrb,
    input  logic                      s2_axi_wvalid,
    output logic                      s2_axi_wready,
    output logic [1:0]                s2_axi_bresp,
    output logic                      s2_axi_bvalid,
    input  logic                      s2_axi_bready,
    input  logic [ADDR_WIDTH-1:0]     s2_axi_araddr,
    input  logic                      s2_axi_arvalid,
    output logic                      s2_axi_arready,
    output logic [DATA_WIDTH-1:0]     s2_axi_rdata,
    output logic [1:0]                s2_axi_rresp,
    output logic                      s2_axi_rvalid,
    input  logic                      s2_axi_rready
);
    localparam int ACC_W = 2 * OP_WIDTH;
    localparam int CNT_W = $clog2(OP_WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
    state_t state, state_nxt;

    logic                ctrl_signed, ctrl_accum, done, ovf, neg;
    logic [OP_WIDTH-1:0] op_a, op_b, mplier, mag_a, mag_b;
    logic [ACC_W-1:0]    acc, prod, mcand, prod_fin;
    logic [ACC_W:0]      sum;
    logic                add_ovf;
    logic [CNT_W-1:0]    cnt;
    logic                busy;
    logic                aw_w_rdy;
    logic                wr_fire, rd_fire;
    logic [2:0]          wr_idx, rd_idx;
    logic                wr_err, start_go, clr_go, ctrl_we, op_a_we, op_b_we;
    logic [31:0]         wmask, op_a_new, op_b_new, rd_mux;
    logic signed [63:0]  s_ext;
    logic [63:0]         u_ext, res64;
    logic                unused_addr;

    assign busy           = (state != IDLE);
    assign s2_axi_awready = aw_w_rdy;
    assign s2_axi_wready  = aw_w_rdy;
    assign s2_axi_rresp   = 2'b00;
    assign wr_fire        = aw_w_rdy && s2_axi_awvalid && s2_axi_wvalid;
    assign rd_fire        = s2_axi_arready && s2_axi_arvalid;
    assign wr_idx         = s2_axi_awaddr[4:2];
    assign rd_idx         = s2_axi_araddr[4:2];
    assign unused_addr    = ^{s2_axi_awaddr[ADDR_WIDTH-1:5], s2_axi_awaddr[1:0],
                              s2_axi_araddr[ADDR_WIDTH-1:5], s2_axi_araddr[1:0]};

    assign wmask    = {{8{s2_axi_wstrb[3]}}, {8{s2_axi_wstrb[2]}},
                       {8{s2_axi_wstrb[1]}}, {8{s2_axi_wstrb[0]}}};
    assign op_a_new = (32'(op_a) & ~wmask) | (s2_axi_wdata & wmask);
    assign op_b_new = (32'(op_b) & ~wmask) | (s2_axi_wdata & wmask);

    // Signedness for a new run comes from the CTRL write that carries START.
    assign mag_a = (s2_axi_wdata[1] && op_a[OP_WIDTH-1]) ? -op_a : op_a;
    assign mag_b = (s2_axi_wdata[1] && op_b[OP_WIDTH-1]) ? -op_b : op_b;

    assign prod_fin = neg ? -prod : prod;
    assign sum      = {1'b0, acc} + {1'b0, prod_fin};
    assign add_ovf  = ctrl_signed ? ((acc[ACC_W-1] == prod_fin[ACC_W-1]) &&
                                     (sum[ACC_W-1] != acc[ACC_W-1]))
                                  : sum[ACC_W];

    always_comb begin
        wr_err   = 1'b0;
        start_go = 1'b0;
        clr_go   = 1'b0;
        ctrl_we  = 1'b0;
        op_a_we  = 1'b0;
        op_b_we  = 1'b0;
        if (wr_fire) begin
            case (wr_idx)
                3'd0: if (s2_axi_wstrb[0]) begin
                    if (busy) begin
                        wr_err = 1'b1;
                    end else begin
                        ctrl_we  = 1'b1;
                        start_go = s2_axi_wdata[0];
                        clr_go   = s2_axi_wdata[3];
                    end
                end
                3'd4: if (busy) wr_err = 1'b1; else op_a_we = 1'b1;
                3'd5: if (busy) wr_err = 1'b1; else op_b_we = 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_go) state_nxt = RUN;
            RUN:     if (cnt == CNT_W'(1)) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge s2_axi_aclk or posedge s2_axi_areset) begin
        if (s2_axi_areset) state <= IDLE;
        else               state <= state_nxt;
    end

    always_ff @(posedge s2_axi_aclk or posedge s2_axi_areset) begin
        if (s2_axi_areset) begin
            ctrl_signed <= 1'b0;
            ctrl_accum  <= 1'b0;
            op_a        <= '0;
            op_b        <= '0;
            acc         <= '0;
            prod        <= '0;
            mcand       <= '0;
            mplier      <= '0;
            cnt         <= '0;
            neg         <= 1'b0;
            done        <= 1'b0;
            ovf         <= 1'b0;
        end else begin
            if (ctrl_we) begin
                ctrl_signed <= s2_axi_wdata[1];
                ctrl_accum  <= s2_axi_wdata[2];
            end
            if (op_a_we) op_a <= op_a_new[OP_WIDTH-1:0];
            if (op_b_we) op_b <= op_b_new[OP_WIDTH-1:0];
            if (clr_go) begin
                acc  <= '0;
                ovf  <= 1'b0;
                done <= 1'b0;
            end
            case (state)
                IDLE: if (start_go) begin
                    mcand  <= ACC_W'(mag_a);
                    mplier <= mag_b;
                    prod   <= '0;
                    cnt    <= CNT_W'(OP_WIDTH);
                    neg    <= s2_axi_wdata[1] & (op_a[OP_WIDTH-1] ^ op_b[OP_WIDTH-1]);
                    done   <= 1'b0;
                end
                RUN: begin
                    if (mplier[0]) prod <= prod + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt - CNT_W'(1);
                end
                FIN: begin
                    acc  <= ctrl_accum ? sum[ACC_W-1:0] : prod_fin;
                    if (ctrl_accum && add_ovf) ovf <= 1'b1;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge s2_axi_aclk or posedge s2_axi_areset) begin
        if (s2_axi_areset) begin
            aw_w_rdy      <= 1'b0;
            s2_axi_bvalid <= 1'b0;
            s2_axi_bresp  <= 2'b00;
        end else begin
            aw_w_rdy <= s2_axi_awvalid && s2_axi_wvalid && !s2_axi_bvalid && !aw_w_rdy;
            if (wr_fire) begin
                s2_axi_bvalid <= 1'b1;
                s2_axi_bresp  <= wr_err ? 2'b10 : 2'b00;
            end else if (s2_axi_bvalid && s2_axi_bready) begin
                s2_axi_bvalid <= 1'b0;
            end
        end
    end

    assign s_ext = $signed(acc);
    assign u_ext = 64'(acc);
    assign res64 = ctrl_signed ? s_ext : u_ext;

    always_comb begin
        rd_mux = 32'd0;
        case (rd_idx)
            3'd0:    rd_mux = 32'({ctrl_accum, ctrl_signed, 1'b0});
            3'd1:    rd_mux = 32'({ovf, done, busy});
            3'd4:    rd_mux = 32'(op_a);
            3'd5:    rd_mux = 32'(op_b);
            3'd6:    rd_mux = res64[31:0];
            3'd7:    rd_mux = res64[63:32];
            default: rd_mux = 32'd0;
        endcase
    end

    always_ff @(posedge s2_axi_aclk or posedge s2_axi_areset) begin
        if (s2_axi_areset) begin
            s2_axi_arready <= 1'b0;
            s2_axi_rvalid  <= 1'b0;
            s2_axi_rdata   <= '0;
        end else begin
            s2_axi_arready <= s2_axi_arvalid && !s2_axi_rvalid && !s2_axi_arready;
            if (rd_fire) begin
                s2_axi_rvalid <= 1'b1;
                s2_axi_rdata  <= rd_mux;
            end else if (s2_axi_rvalid && s2_axi_rready) begin
                s2_axi_rvalid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_seq_mac_axil.sv
// tb/tb_seq_mac_axil.sv - directed self-checking bench for seq_mac_axil
module tb_seq_mac_axil;
    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  awaddr, araddr;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    int          checks = 0;
    int          passed = 0;
    int          busy_total = 0;

    always #5 clk = ~clk;

    always @(negedge clk) if (dut.busy) busy_total++;

    seq_mac_axil dut (
        .s2_axi_aclk(clk), .s2_axi_areset(rst),
        .s2_axi_awaddr(awaddr), .s2_axi_awvalid(awvalid), .s2_axi_awready(awready),
        .s2_axi_wdata(wdata), .s2_axi_wstrb(wstrb), .s2_axi_wvalid(wvalid), .s2_axi_wready(wready),
        .s2_axi_bresp(bresp), .s2_axi_bvalid(bvalid), .s2_axi_bready(bready),
        .s2_axi_araddr(araddr), .s2_axi_arvalid(arvalid), .s2_axi_arready(arready),
        .s2_axi_rdata(rdata), .s2_axi_rresp(rresp), .s2_axi_rvalid(rvalid), .s2_axi_rready(rready)
    );

    task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] r);
        int n;
        r = 2'b11;
        @(negedge clk);
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        n = 0;
        while (!awready && n < 20) begin @(negedge clk); n++; end
        if (!awready) begin
            checks++;
            $display("FAIL write_timeout addr=%h: awready=0 after %0d cycles, expected 1", a, n);
            awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
            return;
        end
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (!bvalid && n < 20) begin @(negedge clk); n++; end
        if (!bvalid) begin
            checks++;
            $display("FAIL bvalid_timeout addr=%h: bvalid=0, expected 1", a);
        end
        r = bresp;
        @(posedge clk); #1;
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] r);
        int n;
        d = 32'hDEAD_BEEF; r = 2'b11;
        @(negedge clk);
        araddr = a; arvalid = 1'b1;
        n = 0;
        while (!arready && n < 20) begin @(negedge clk); n++; end
        if (!arready) begin
            checks++;
            $display("FAIL read_timeout addr=%h: arready=0 after %0d cycles, expected 1", a, n);
            arvalid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 20) begin @(negedge clk); n++; end
        if (!rvalid) begin
            checks++;
            $display("FAIL rvalid_timeout addr=%h: rvalid=0, expected 1", a);
        end
        d = rdata; r = rresp;
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
    endtask

    task automatic wait_done();
        logic [31:0] st;
        logic [1:0]  r;
        st = '0;
        for (int i = 0; i < 60; i++) begin
            axi_read(8'h04, st, r);
            if (st[1]) break;
        end
        if (!st[1]) begin
            checks++;
            $display("FAIL done_timeout: STATUS=%h, expected DONE=1", st);
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic [1:0]  r;
        repeat (2) @(negedge clk);
        checks++;
        if ({awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata} !== 41'd0)
            $display("FAIL reset_outputs: got aw=%b w=%b ar=%b b=%b r=%b bresp=%b rresp=%b rdata=%h, expected all 0",
                     awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata);
        else passed++;
        rst = 1'b0;
        axi_read(8'h04, d, r);
        checks++; if (d !== 32'h0) $display("FAIL reset_status: got %h expected 0", d); else passed++;
        axi_read(8'h18, d, r);
        checks++; if (d !== 32'h0) $display("FAIL reset_result_lo: got %h expected 0", d); else passed++;
        axi_read(8'h00, d, r);
        checks++; if (d !== 32'h0) $display("FAIL reset_ctrl: got %h expected 0", d); else passed++;
        checks++; if (r !== 2'b00) $display("FAIL reset_rresp: got %b expected 00", r); else passed++;
    endtask

    task automatic test_unsigned();
        logic [31:0] d;
        logic [1:0]  r;
        int          b0;
        axi_write(8'h10, 32'h278, 4'hF, r);
        axi_write(8'h14, 32'h1468, 4'hF, r);
        b0 = busy_total;
        axi_write(8'h00, 32'h1, 4'hF, r);
        checks++; if (r !== 2'b00) $display("FAIL unsigned_start_bresp: got %b expected 00", r); else passed++;
        axi_read(8'h04, d, r);
        checks++; if (d !== 32'h1) $display("FAIL unsigned_busy_status: got %h expected 1", d); else passed++;
        wait_done();
        checks++;
        if (busy_total - b0 != 33) $display("FAIL unsigned_busy_cycles: got %0d expected 33", busy_total - b0);
        else passed++;
        axi_read(8'h18, d, r);
        checks++; if (d !== 32'h003260C0) $display("FAIL unsigned_lo: got %h expected 003260c0", d); else passed++;
        axi_read(8'h1C, d, r);
        checks++; if (d !== 32'h0) $display("FAIL unsigned_hi: got %h expected 0", d); else passed++;
        axi_read(8'h00, d, r);
        checks++; if (d !== 32'h0) $display("FAIL unsigned_ctrl_readback: got %h expected 0", d); else passed++;
    endtask

    task automatic test_signed();
        logic [31:0] d;
        logic [1:0]  r;
        axi_write(8'h10, 32'hFFFFFFFD, 4'hF, r);
        axi_write(8'h14, 32'h7, 4'hF, r);
        axi_write(8'h00, 32'h3, 4'hF, r);
        axi_read(8'h04, d, r);
        checks++; if (d !== 32'h1) $display("FAIL signed_done_cleared: got %h expected 1", d); else passed++;
        wait_done();
        axi_read(8'h1C, d, r);
        checks++; if (d !== 32'hFFFFFFFF) $display("FAIL signed_hi: got %h expected ffffffff", d); else passed++;
        axi_read(8'h18, d, r);
        checks++; if (d !== 32'hFFFFFFEB) $display("FAIL signed_lo: got %h expected ffffffeb", d); else passed++;
        axi_read(8'h04, d, r);
        checks++; if (d !== 32'h2) $display("FAIL signed_status: got %h expected 2", d); else passed++;
    endtask

    task automatic test_accum();
        logic [31:0] d;
        logic [1:0]  r;
        axi_write(8'h00, 32'h8, 4'hF, r);
        axi_read(8'h04, d, r);
        checks++; if (d !== 32'h0) $display("FAIL clr_status: got %h expected 0", d); else passed++;
        axi_write(8'h10, 32'h278, 4'hF, r);
        axi_write(8'h14, 32'h1468, 4'hF, r);
        axi_write(8'h00, 32'h5, 4'hF, r);
        wait_done();
        axi_write(8'h00, 32'h5, 4'hF, r);
        wait_done();
        axi_read(8'h18, d, r);
        checks++; if (d !== 32'h0064C180) $display("FAIL accum_lo: got %h expected 0064c180", d); else passed++;
        axi_read(8'h1C, d, r);
        checks++; if (d !== 32'h0) $display("FAIL accum_hi: got %h expected 0", d); else passed++;
    endtask

    task automatic test_accum_ovf();
        logic [31:0] d;
        logic [1:0]  r;
        axi_write(8'h00, 32'h8, 4'hF, r);
        axi_write(8'h10, 32'hFFFFFFFF, 4'hF, r);
        axi_write(8'h14, 32'hFFFFFFFF, 4'hF, r);
        axi_write(8'h00, 32'h5, 4'hF, r);
        wait_done();
        axi_read(8'h04, d, r);
        checks++; if (d !== 32'h2) $display("FAIL ovf_first_status: got %h expected 2", d); else passed++;
        axi_read(8'h1C, d, r);
        checks++; if (d !== 32'hFFFFFFFE) $display("FAIL ovf_first_hi: got %h expected fffffffe", d); else passed++;
        axi_write(8'h00, 32'h5, 4'hF, r);
        wait_done();
        axi_read(8'h18, d, r);
        checks++; if (d !== 32'h2) $display("FAIL ovf_lo: got %h expected 00000002", d); else passed++;
        axi_read(8'h1C, d, r);
        checks++; if (d !== 32'hFFFFFFFC) $display("FAIL ovf_hi: got %h expected fffffffc", d); else passed++;
        axi_read(8'h04, d, r);
        checks++; if (d !== 32'h6) $display("FAIL ovf_status: got %h expected 6", d); else passed++;
    endtask

    task automatic test_busy_protect();
        logic [31:0] d;
        logic [1:0]  r;
        axi_write(8'h10, 32'h278, 4'hF, r);
        axi_write(8'h14, 32'h1468, 4'hF, r);
        axi_write(8'h00, 32'h1, 4'hF, r);
        axi_write(8'h10, 32'h55, 4'hF, r);
        checks++; if (r !== 2'b10) $display("FAIL busy_opa_bresp: got %b expected 10", r); else passed++;
        axi_write(8'h00, 32'h9, 4'hF, r);
        checks++; if (r !== 2'b10) $display("FAIL busy_ctrl_bresp: got %b expected 10", r); else passed++;
        axi_write(8'h08, 32'h1, 4'hF, r);
        checks++; if (r !== 2'b00) $display("FAIL busy_unmapped_bresp: got %b expected 00", r); else passed++;
        wait_done();
        axi_read(8'h10, d, r);
        checks++; if (d !== 32'h278) $display("FAIL busy_opa_kept: got %h expected 00000278", d); else passed++;
        axi_read(8'h18, d, r);
        checks++; if (d !== 32'h003260C0) $display("FAIL busy_result: got %h expected 003260c0", d); else passed++;
    endtask

    task automatic test_strobe_unmapped();
        logic [31:0] d;
        logic [1:0]  r;
        axi_write(8'h10, 32'hAABBCCDD, 4'hF, r);
        axi_write(8'h10, 32'h11223344, 4'h5, r);
        axi_read(8'h10, d, r);
        checks++; if (d !== 32'hAA22CC44) $display("FAIL strobe_opa: got %h expected aa22cc44", d); else passed++;
        axi_write(8'h00, 32'h6, 4'hF, r);
        axi_write(8'h00, 32'h0, 4'hE, r);
        axi_read(8'h00, d, r);
        checks++; if (d !== 32'h6) $display("FAIL strobe_ctrl: got %h expected 6", d); else passed++;
        axi_write(8'h0C, 32'h12345678, 4'hF, r);
        checks++; if (r !== 2'b00) $display("FAIL unmapped_bresp: got %b expected 00", r); else passed++;
        axi_read(8'h0C, d, r);
        checks++; if (d !== 32'h0 || r !== 2'b00) $display("FAIL unmapped_read: got %h/%b expected 0/00", d, r); else passed++;
        axi_write(8'h00, 32'h0, 4'hF, r);
    endtask

    task automatic test_handshake();
        logic [31:0] d;
        logic [1:0]  r;
        int          n;
        logic        bad;
        @(negedge clk);
        awaddr = 8'h10; wdata = 32'h11; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        n = 0;
        while (!awready && n < 20) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        wdata = 32'h22;
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if ({bvalid, bresp, awready} !== 4'b1000) bad = 1'b1;
        end
        checks++;
        if (bad) $display("FAIL bready_hold: got bvalid=%b bresp=%b awready=%b expected 1/00/0", bvalid, bresp, awready);
        else passed++;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        checks++; if (bvalid !== 1'b0) $display("FAIL bvalid_release: got %b expected 0", bvalid); else passed++;
        axi_read(8'h10, d, r);
        checks++; if (d !== 32'h11) $display("FAIL bready_hold_opa: got %h expected 00000011", d); else passed++;

        @(negedge clk);
        araddr = 8'h10; arvalid = 1'b1;
        n = 0;
        while (!arready && n < 20) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        arvalid = 1'b0;
        axi_write(8'h10, 32'h33, 4'hF, r);
        repeat (2) @(negedge clk);
        checks++;
        if (rvalid !== 1'b1 || rdata !== 32'h11) $display("FAIL rready_hold: got rvalid=%b rdata=%h expected 1/00000011", rvalid, rdata);
        else passed++;
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
        axi_read(8'h10, d, r);
        checks++; if (d !== 32'h33) $display("FAIL concurrent_write_opa: got %h expected 00000033", d); else passed++;

        @(negedge clk);
        awaddr = 8'h14; wdata = 32'h99; awvalid = 1'b1; wvalid = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (awready !== 1'b0) bad = 1'b1;
        end
        awvalid = 1'b0;
        checks++; if (bad) $display("FAIL lone_aw: awready=1 seen, expected 0"); else passed++;
    endtask

    task automatic test_reset_mid_run();
        logic [31:0] d;
        logic [1:0]  r;
        axi_write(8'h10, 32'h278, 4'hF, r);
        axi_write(8'h14, 32'h1468, 4'hF, r);
        axi_write(8'h00, 32'h1, 4'hF, r);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({awready, wready, arready, bvalid, rvalid} !== 5'b0)
            $display("FAIL midrun_reset_outputs: got aw=%b w=%b ar=%b b=%b r=%b expected all 0",
                     awready, wready, arready, bvalid, rvalid);
        else passed++;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        axi_read(8'h04, d, r);
        checks++; if (d !== 32'h0) $display("FAIL midrun_status: got %h expected 0", d); else passed++;
        axi_read(8'h18, d, r);
        checks++; if (d !== 32'h0) $display("FAIL midrun_result_lo: got %h expected 0", d); else passed++;
        axi_read(8'h1C, d, r);
        checks++; if (d !== 32'h0) $display("FAIL midrun_result_hi: got %h expected 0", d); else passed++;
        axi_read(8'h10, d, r);
        checks++; if (d !== 32'h0) $display("FAIL midrun_opa: got %h expected 0", d); else passed++;
        axi_write(8'h10, 32'h3, 4'hF, r);
        axi_write(8'h14, 32'h5, 4'hF, r);
        axi_write(8'h00, 32'h1, 4'hF, r);
        wait_done();
        axi_read(8'h18, d, r);
        checks++; if (d !== 32'd15) $display("FAIL post_reset_mult: got %h expected 0000000f", d); else passed++;
    endtask

    initial begin
        rst = 1'b1;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arvalid = 1'b0; rready = 1'b0;
        test_reset();
        test_unsigned();
        test_signed();
        test_accum();
        test_accum_ovf();
        test_busy_protect();
        test_strobe_unmapped();
        test_handshake();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
